// File: rtl/i2c_master_arbiter.sv
// Purpose: round-robin share of one i2c_master between two requesters; latches winner command, steers strobes back.
// Latency: i_req_valid seen in IDLE at cycle n -> o_start/o_req_ack in cycle n+1; byte strobes -> requester pulses +1 cycle.
// Backpressure: requests are level-held; while busy or in the post-transfer gap they wait and are never dropped.
module i2c_master_arbiter #(
    parameter int G_GAP_CYCLES = 64,
    parameter int G_TIMEOUT    = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  i_req_valid,
    input  logic [1:0]  i_req_rw,
    input  logic [13:0] i_req_chip_addr,
    input  logic [15:0] i_req_nb_data,
    input  logic [15:0] i_req_wdata,
    output logic [1:0]  o_req_ack,
    output logic [1:0]  o_req_wdata_rdy,
    output logic [7:0]  o_req_rdata,
    output logic [1:0]  o_req_rdata_valid,
    output logic [1:0]  o_req_done,
    output logic [1:0]  o_req_err,
    output logic        o_busy,
    output logic        o_start,
    output logic        o_rw,
    output logic [6:0]  o_chip_addr,
    output logic [7:0]  o_nb_data,
    output logic [7:0]  o_wdata,
    input  logic [7:0]  i_rdata,
    input  logic        i_rdata_valid,
    input  logic        i_next_wdata_rdy,
    input  logic        i_sack_error
);
    localparam int TW = (G_TIMEOUT > 1) ? $clog2(G_TIMEOUT) : 1;
    localparam int GW = (G_GAP_CYCLES > 1) ? $clog2(G_GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(G_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(G_GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, XFER, GAP} state_t;

    state_t        state;
    logic          grant;
    logic          rr_prio;
    logic [7:0]    byte_cnt;
    logic [TW-1:0] timer;
    logic [GW-1:0] gap_cnt;

    logic          win;
    logic [1:0]    win_oh;
    logic [1:0]    grant_oh;
    logic [6:0]    win_addr;
    logic [7:0]    win_nb;
    logic          byte_evt;
    logic          last_byte;

    // With both requesting, rr_prio names the one that was not served last.
    always_comb begin
        win = i_req_valid[1];
        if (i_req_valid == 2'b11) begin
            win = rr_prio;
        end
    end

    assign win_oh    = win   ? 2'b10 : 2'b01;
    assign grant_oh  = grant ? 2'b10 : 2'b01;
    assign win_addr  = win ? i_req_chip_addr[13:7] : i_req_chip_addr[6:0];
    assign win_nb    = win ? i_req_nb_data[15:8]   : i_req_nb_data[7:0];
    assign byte_evt  = o_rw ? i_rdata_valid : i_next_wdata_rdy;
    assign last_byte = (byte_cnt + 8'd1) == o_nb_data;

    assign o_busy  = (state != IDLE);
    // The granted requester's live write byte; it refreshes it after each wdata_rdy pulse.
    assign o_wdata = (state == IDLE) ? 8'h00 : (grant ? i_req_wdata[15:8] : i_req_wdata[7:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            grant             <= 1'b0;
            rr_prio           <= 1'b0;
            byte_cnt          <= 8'd0;
            timer             <= '0;
            gap_cnt           <= '0;
            o_req_ack         <= 2'b00;
            o_req_wdata_rdy   <= 2'b00;
            o_req_rdata       <= 8'h00;
            o_req_rdata_valid <= 2'b00;
            o_req_done        <= 2'b00;
            o_req_err         <= 2'b00;
            o_start           <= 1'b0;
            o_rw              <= 1'b0;
            o_chip_addr       <= 7'h00;
            o_nb_data         <= 8'h00;
        end else begin
            o_start           <= 1'b0;
            o_req_ack         <= 2'b00;
            o_req_wdata_rdy   <= 2'b00;
            o_req_rdata_valid <= 2'b00;
            o_req_done        <= 2'b00;
            o_req_err         <= 2'b00;
            case (state)
                IDLE: begin
                    if (|i_req_valid) begin
                        grant       <= win;
                        rr_prio     <= ~win;
                        o_rw        <= i_req_rw[win];
                        o_chip_addr <= win_addr;
                        o_nb_data   <= win_nb;
                        if (win_nb == 8'd0) begin
                            // Empty command: acknowledged and failed without touching the bus.
                            o_req_ack  <= win_oh;
                            o_req_done <= win_oh;
                            o_req_err  <= win_oh;
                            gap_cnt    <= '0;
                            state      <= GAP;
                        end else begin
                            o_start   <= 1'b1;
                            o_req_ack <= win_oh;
                            state     <= START;
                        end
                    end
                end
                START: begin
                    byte_cnt <= 8'd0;
                    timer    <= '0;
                    state    <= XFER;
                end
                XFER: begin
                    if (i_sack_error) begin
                        o_req_done <= grant_oh;
                        o_req_err  <= grant_oh;
                        gap_cnt    <= '0;
                        state      <= GAP;
                    end else if (byte_evt) begin
                        byte_cnt <= byte_cnt + 8'd1;
                        timer    <= '0;
                        if (o_rw) begin
                            o_req_rdata       <= i_rdata;
                            o_req_rdata_valid <= grant_oh;
                        end
                        if (last_byte) begin
                            o_req_done <= grant_oh;
                            gap_cnt    <= '0;
                            state      <= GAP;
                        end else if (!o_rw) begin
                            o_req_wdata_rdy <= grant_oh;
                        end
                    end else if (timer == TIMER_LAST) begin
                        o_req_done <= grant_oh;
                        o_req_err  <= grant_oh;
                        gap_cnt    <= '0;
                        state      <= GAP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench: the bench plays both requesters and the i2c_master side, one task per scenario.
module tb_i2c_master_arbiter;
    localparam int GAP = 8;
    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  i_req_valid = 2'b00;
    logic [1:0]  i_req_rw = 2'b00;
    logic [13:0] i_req_chip_addr = '0;
    logic [15:0] i_req_nb_data = '0;
    logic [15:0] i_req_wdata = '0;
    logic [1:0]  o_req_ack, o_req_wdata_rdy, o_req_rdata_valid, o_req_done, o_req_err;
    logic [7:0]  o_req_rdata;
    logic        o_busy, o_start, o_rw;
    logic [6:0]  o_chip_addr;
    logic [7:0]  o_nb_data, o_wdata;
    logic [7:0]  i_rdata = 8'h00;
    logic        i_rdata_valid = 1'b0;
    logic        i_next_wdata_rdy = 1'b0;
    logic        i_sack_error = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int starts = 0;

    i2c_master_arbiter #(.G_GAP_CYCLES(GAP), .G_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_rw(i_req_rw), .i_req_chip_addr(i_req_chip_addr),
        .i_req_nb_data(i_req_nb_data), .i_req_wdata(i_req_wdata),
        .o_req_ack(o_req_ack), .o_req_wdata_rdy(o_req_wdata_rdy), .o_req_rdata(o_req_rdata),
        .o_req_rdata_valid(o_req_rdata_valid), .o_req_done(o_req_done), .o_req_err(o_req_err),
        .o_busy(o_busy), .o_start(o_start), .o_rw(o_rw), .o_chip_addr(o_chip_addr),
        .o_nb_data(o_nb_data), .o_wdata(o_wdata),
        .i_rdata(i_rdata), .i_rdata_valid(i_rdata_valid),
        .i_next_wdata_rdy(i_next_wdata_rdy), .i_sack_error(i_sack_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_start === 1'b1) starts <= starts + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One-cycle master-side strobe; returns on the following negedge with the DUT's response visible.
    task automatic strobe(input logic wr, input logic rd, input logic se, input logic [7:0] byte_in);
        i_next_wdata_rdy = wr;
        i_rdata_valid    = rd;
        i_sack_error     = se;
        i_rdata          = byte_in;
        @(negedge clk);
        i_next_wdata_rdy = 1'b0;
        i_rdata_valid    = 1'b0;
        i_sack_error     = 1'b0;
    endtask

    task automatic wait_start(output logic found, output int at_cyc);
        found  = 1'b0;
        at_cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_start === 1'b1) begin
                found  = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic wait_idle(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (o_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({o_start, o_req_ack, o_req_done, o_req_err, o_req_wdata_rdy, o_req_rdata_valid, o_busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_ctrl: got %h want 000", {o_start, o_req_ack, o_req_done, o_req_err, o_req_wdata_rdy, o_req_rdata_valid, o_busy});
        end
        checks++;
        if ({o_req_rdata, o_wdata, o_chip_addr, o_nb_data, o_rw} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {o_req_rdata, o_wdata, o_chip_addr, o_nb_data, o_rw});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy got %b want 0", o_busy); end
    endtask

    task automatic test_write();
        logic found, ok;
        int t, s0;
        s0 = starts;
        i_req_rw = 2'b00; i_req_chip_addr = {7'h00, 7'h50}; i_req_nb_data = 16'h0003; i_req_wdata = 16'h00A1;
        i_req_valid = 2'b01;
        wait_start(found, t);
        checks++;
        if (found !== 1'b1) begin errors++; $display("FAIL wr_start: no o_start seen"); end
        checks++;
        if (o_req_ack !== 2'b01) begin errors++; $display("FAIL wr_ack: got %b want 01", o_req_ack); end
        checks++;
        if ({o_rw, o_chip_addr, o_nb_data} !== {1'b0, 7'h50, 8'd3}) begin
            errors++; $display("FAIL wr_fields: got %h want %h", {o_rw, o_chip_addr, o_nb_data}, {1'b0, 7'h50, 8'd3});
        end
        checks++;
        if (o_wdata !== 8'hA1) begin errors++; $display("FAIL wr_byte0: got %h want a1", o_wdata); end
        i_req_valid = 2'b00;
        repeat (2) @(negedge clk);
        strobe(1'b0, 1'b1, 1'b0, 8'hEE);
        checks++;
        if ({o_req_rdata_valid, o_req_wdata_rdy, o_req_done} !== 6'b0) begin
            errors++; $display("FAIL wr_ignore_rd: got %b want 000000", {o_req_rdata_valid, o_req_wdata_rdy, o_req_done});
        end
        strobe(1'b1, 1'b0, 1'b0, 8'h00);
        checks++;
        if (o_req_wdata_rdy !== 2'b01) begin errors++; $display("FAIL wr_rdy1: got %b want 01", o_req_wdata_rdy); end
        i_req_wdata = 16'h00B2;
        @(negedge clk);
        checks++;
        if (o_wdata !== 8'hB2) begin errors++; $display("FAIL wr_byte1: got %h want b2", o_wdata); end
        strobe(1'b1, 1'b0, 1'b0, 8'h00);
        checks++;
        if (o_req_wdata_rdy !== 2'b01) begin errors++; $display("FAIL wr_rdy2: got %b want 01", o_req_wdata_rdy); end
        i_req_wdata = 16'h00C3;
        @(negedge clk);
        checks++;
        if (o_wdata !== 8'hC3) begin errors++; $display("FAIL wr_byte2: got %h want c3", o_wdata); end
        strobe(1'b1, 1'b0, 1'b0, 8'h00);
        checks++;
        if ({o_req_wdata_rdy, o_req_done, o_req_err} !== 6'b00_01_00) begin
            errors++; $display("FAIL wr_done: got %b want 000100", {o_req_wdata_rdy, o_req_done, o_req_err});
        end
        wait_idle(ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL wr_idle: busy never dropped"); end
        checks++;
        if (starts - s0 !== 1) begin errors++; $display("FAIL wr_one_start: got %0d want 1", starts - s0); end
    endtask

    task automatic test_read();
        logic found, ok;
        int t;
        i_req_rw = 2'b10; i_req_chip_addr = {7'h50, 7'h00}; i_req_nb_data = 16'h0200;
        i_req_valid = 2'b10;
        wait_start(found, t);
        checks++;
        if ({found, o_req_ack, o_rw, o_chip_addr, o_nb_data} !== {1'b1, 2'b10, 1'b1, 7'h50, 8'd2}) begin
            errors++; $display("FAIL rd_start: got %h want %h", {found, o_req_ack, o_rw, o_chip_addr, o_nb_data}, {1'b1, 2'b10, 1'b1, 7'h50, 8'd2});
        end
        i_req_valid = 2'b00;
        repeat (2) @(negedge clk);
        strobe(1'b1, 1'b0, 1'b0, 8'h00);
        checks++;
        if ({o_req_wdata_rdy, o_req_rdata_valid} !== 4'b0) begin
            errors++; $display("FAIL rd_ignore_wr: got %b want 0000", {o_req_wdata_rdy, o_req_rdata_valid});
        end
        strobe(1'b0, 1'b1, 1'b0, 8'h5A);
        checks++;
        if ({o_req_rdata_valid, o_req_rdata, o_req_done} !== {2'b10, 8'h5A, 2'b00}) begin
            errors++; $display("FAIL rd_byte0: got %h want %h", {o_req_rdata_valid, o_req_rdata, o_req_done}, {2'b10, 8'h5A, 2'b00});
        end
        strobe(1'b0, 1'b1, 1'b0, 8'hA5);
        checks++;
        if ({o_req_rdata_valid, o_req_rdata, o_req_done, o_req_err} !== {2'b10, 8'hA5, 2'b10, 2'b00}) begin
            errors++; $display("FAIL rd_byte1: got %h want %h", {o_req_rdata_valid, o_req_rdata, o_req_done, o_req_err}, {2'b10, 8'hA5, 2'b10, 2'b00});
        end
        wait_idle(ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL rd_idle: busy never dropped"); end
    endtask

    task automatic test_round_robin();
        logic found, ok;
        int t, t_prev;
        logic [7:0] order;
        logic [1:0] want;
        order = 8'b10_01_10_01;
        i_req_rw = 2'b00; i_req_chip_addr = {7'h50, 7'h50}; i_req_nb_data = 16'h0101; i_req_wdata = 16'h2211;
        i_req_valid = 2'b11;
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) i_req_valid = 2'b11;
            want = order[2*i +: 2];
            wait_start(found, t);
            checks++;
            if ({found, o_req_ack} !== {1'b1, want}) begin
                errors++; $display("FAIL rr_order%0d: got %b want %b", i, {found, o_req_ack}, {1'b1, want});
            end
            checks++;
            if (o_wdata !== (want[1] ? 8'h22 : 8'h11)) begin
                errors++; $display("FAIL rr_wdata%0d: got %h want %h", i, o_wdata, want[1] ? 8'h22 : 8'h11);
            end
            if (i > 0) begin
                checks++;
                if (t - t_prev <= GAP) begin
                    errors++; $display("FAIL rr_gap%0d: got %0d cycles want > %0d", i, t - t_prev, GAP);
                end
            end
            t_prev = t;
            i_req_valid = i_req_valid & ~want;
            @(negedge clk);
            strobe(1'b1, 1'b0, 1'b0, 8'h00);
            checks++;
            if (o_req_done !== want) begin errors++; $display("FAIL rr_done%0d: got %b want %b", i, o_req_done, want); end
        end
        wait_idle(ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL rr_idle: busy never dropped"); end
    endtask

    task automatic test_sack_error();
        logic found, ok;
        int t;
        i_req_rw = 2'b00; i_req_chip_addr = {7'h00, 7'h51}; i_req_nb_data = 16'h0002; i_req_wdata = 16'h0077;
        i_req_valid = 2'b01;
        wait_start(found, t);
        checks++;
        if ({found, o_req_ack} !== 3'b101) begin errors++; $display("FAIL sack_start: got %b want 101", {found, o_req_ack}); end
        i_req_valid = 2'b00;
        @(negedge clk);
        strobe(1'b1, 1'b0, 1'b1, 8'h00);
        checks++;
        if ({o_req_wdata_rdy, o_req_done, o_req_err} !== 6'b00_01_01) begin
            errors++; $display("FAIL sack_err: got %b want 000101", {o_req_wdata_rdy, o_req_done, o_req_err});
        end
        i_req_rw = 2'b10; i_req_chip_addr = {7'h50, 7'h00}; i_req_nb_data = 16'h0100;
        i_req_valid = 2'b10;
        wait_start(found, t);
        checks++;
        if ({found, o_req_ack} !== 3'b110) begin errors++; $display("FAIL sack_next: got %b want 110", {found, o_req_ack}); end
        i_req_valid = 2'b00;
        @(negedge clk);
        strobe(1'b0, 1'b1, 1'b0, 8'h3C);
        checks++;
        if ({o_req_done, o_req_err, o_req_rdata} !== {2'b10, 2'b00, 8'h3C}) begin
            errors++; $display("FAIL sack_next_done: got %h want %h", {o_req_done, o_req_err, o_req_rdata}, {2'b10, 2'b00, 8'h3C});
        end
        wait_idle(ok);
    endtask

    task automatic test_zero_len();
        int s0;
        s0 = starts;
        i_req_rw = 2'b00; i_req_chip_addr = {7'h00, 7'h50}; i_req_nb_data = 16'h0000;
        i_req_valid = 2'b01;
        @(negedge clk);
        checks++;
        if ({o_req_ack, o_req_done, o_req_err, o_start, o_busy} !== 8'b01_01_01_0_1) begin
            errors++; $display("FAIL nb0_pulses: got %b want 01010101", {o_req_ack, o_req_done, o_req_err, o_start, o_busy});
        end
        i_req_valid = 2'b00;
        repeat (GAP + 4) @(negedge clk);
        checks++;
        if (starts !== s0) begin errors++; $display("FAIL nb0_no_start: got %0d starts want 0", starts - s0); end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL nb0_idle: busy got %b want 0", o_busy); end
    endtask

    task automatic test_timeout_and_reset();
        logic found, ok, seen;
        int t, n;
        i_req_rw = 2'b00; i_req_chip_addr = {7'h00, 7'h50}; i_req_nb_data = 16'h0002; i_req_wdata = 16'h0099;
        i_req_valid = 2'b01;
        wait_start(found, t);
        i_req_valid = 2'b00;
        n = 0;
        for (int i = 1; i <= TMO + 20; i++) begin
            @(negedge clk);
            if (o_req_done !== 2'b00) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n !== TMO + 1) begin errors++; $display("FAIL tmo_latency: got %0d want %0d", n, TMO + 1); end
        checks++;
        if ({o_req_done, o_req_err} !== 4'b0101) begin errors++; $display("FAIL tmo_err: got %b want 0101", {o_req_done, o_req_err}); end
        wait_idle(ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL tmo_idle: busy never dropped"); end

        i_req_nb_data = 16'h0003;
        i_req_valid = 2'b01;
        wait_start(found, t);
        i_req_valid = 2'b00;
        @(negedge clk);
        strobe(1'b1, 1'b0, 1'b0, 8'h00);
        checks++;
        if (o_req_wdata_rdy !== 2'b01) begin errors++; $display("FAIL rst_pre: got %b want 01", o_req_wdata_rdy); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({o_start, o_req_ack, o_req_done, o_req_err, o_req_wdata_rdy, o_req_rdata_valid, o_busy} !== 12'h000) begin
            errors++; $display("FAIL rst_async_ctrl: got %h want 000", {o_start, o_req_ack, o_req_done, o_req_err, o_req_wdata_rdy, o_req_rdata_valid, o_busy});
        end
        checks++;
        if ({o_wdata, o_chip_addr, o_nb_data, o_rw} !== 24'h0) begin
            errors++; $display("FAIL rst_async_data: got %h want 0", {o_wdata, o_chip_addr, o_nb_data, o_rw});
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (TMO + GAP + 10) begin
            @(negedge clk);
            if (o_req_done !== 2'b00 || o_start !== 1'b0 || o_busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_done: activity after reset got %b want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_sack_error();
        test_zero_len();
        test_timeout_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
